breadboard_tests_core: RTL and testbench

// - Breadboard bring-up controller: receives 1-byte commands from an FT232H in 245-FIFO mode.
// - Runs MCP3008 ADC conversions over SPI and returns results over the FT232H.
// - Also returns a synthetic CCD test frame, so the full host->FPGA->host path is tested without the CCD.

---
 rtl/breadboard_tests_core.sv | 246 ++++++++++++++++++++++++
 tb/tb_breadboard_tests_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/breadboard_tests_core.sv
// Breadboard bring-up controller: FT232H 245-FIFO command/reply path, MCP3008 SPI reads, synthetic CCD frame.
// Optional feature macro: BB_SEND_IMMEDIATE_EN (pulse ft_siwu_n after the last byte of each reply).
module breadboard_tests_core #(
  parameter logic [7:0] CMD_GET_MCP       = 8'h01,
  parameter logic [7:0] CMD_SHUTTER_CLOSE = 8'h02,
  parameter logic [7:0] CMD_READ_CCD      = 8'h03,
  parameter int         CCD_BYTES         = 64,
  parameter int         SPI_DIV_LOG2      = 5
) (
  input  logic       clk_in,
  input  logic       rst_n,
  inout  wire  [7:0] ft_bus,
  input  logic       ft_rxf_n,
  input  logic       ft_txe_n,
  output logic       ft_rd_n,
  output logic       ft_wr_n,
  output logic       ft_siwu_n,
  input  logic       ft_clkout,
  output logic       ft_oe_n,
  output logic       mcp_dclk,
  input  logic       mcp_dout,
  output logic       mcp_din,
  output logic       mcp_cs_n
);

  typedef enum logic [3:0] {
    IDLE, RD_OE, RD_STB, RD_WAIT, DECODE, MCP_CONV, TX_LOAD, TX_STB, TX_HOLD, SIWU
  } state_t;

  typedef enum logic [1:0] {REP_MCP, REP_ACK, REP_CCD} rep_t;

  localparam logic [8:0] CCD_LAST = 9'(CCD_BYTES);

  state_t                  state;
  rep_t                    rep_kind;
  logic [1:0]              rxf_sync;
  logic [1:0]              txe_sync;
  logic [1:0]              dout_sync;
  logic [7:0]              cmd;
  logic [7:0]              tx_data;
  logic                    tx_drive;
  logic [1:0]              strobe_cnt;
  logic                    shutter_open;
  logic [SPI_DIV_LOG2-1:0] div_cnt;
  logic [5:0]              half_cnt;
  logic                    chan;
  logic [9:0]              shift;
  logic [9:0]              ch0;
  logic [9:0]              ch1;
  logic [8:0]              rep_idx;
  logic [8:0]              rep_last;
  logic [7:0]              rep_byte;
  logic [7:0]              ccd_byte;
  logic                    half_tick;
  logic                    unused_clkout;

  assign unused_clkout = ft_clkout;

  // The bus is only ever driven with the FT232H output enable released.
  assign ft_bus = (tx_drive && ft_oe_n) ? tx_data : 8'hzz;

  assign half_tick = &div_cnt;
  assign ccd_byte  = rep_idx[7:0] - 8'd1;

  always_comb begin
    rep_byte = 8'h00;
    case (rep_kind)
      REP_MCP: begin
        case (rep_idx[1:0])
          2'd0:    rep_byte = {6'b0, ch0[9:8]};
          2'd1:    rep_byte = ch0[7:0];
          2'd2:    rep_byte = {6'b0, ch1[9:8]};
          default: rep_byte = ch1[7:0];
        endcase
      end
      REP_ACK: rep_byte = 8'hA5;
      REP_CCD: rep_byte = (rep_idx == 9'd0) ? {7'b0, shutter_open} : ccd_byte;
      default: rep_byte = 8'h00;
    endcase
  end

`ifndef BB_SEND_IMMEDIATE_EN
  assign ft_siwu_n = 1'b1;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rep_kind     <= REP_ACK;
      rxf_sync     <= 2'b11;
      txe_sync     <= 2'b11;
      dout_sync    <= 2'b00;
      cmd          <= 8'h00;
      tx_data      <= 8'h00;
      tx_drive     <= 1'b0;
      strobe_cnt   <= 2'd0;
      shutter_open <= 1'b1;
      div_cnt      <= '0;
      half_cnt     <= 6'd0;
      chan         <= 1'b0;
      shift        <= 10'd0;
      ch0          <= 10'd0;
      ch1          <= 10'd0;
      rep_idx      <= 9'd0;
      rep_last     <= 9'd0;
      ft_rd_n      <= 1'b1;
      ft_wr_n      <= 1'b1;
      ft_oe_n      <= 1'b1;
      mcp_dclk     <= 1'b0;
      mcp_din      <= 1'b0;
      mcp_cs_n     <= 1'b1;
`ifdef BB_SEND_IMMEDIATE_EN
      ft_siwu_n    <= 1'b1;
`endif
    end else begin
      rxf_sync  <= {rxf_sync[0], ft_rxf_n};
      txe_sync  <= {txe_sync[0], ft_txe_n};
      dout_sync <= {dout_sync[0], mcp_dout};

      case (state)
        IDLE: begin
          if (!rxf_sync[1]) begin
            ft_oe_n <= 1'b0;
            state   <= RD_OE;
          end
        end
        RD_OE: begin
          ft_rd_n    <= 1'b0;
          strobe_cnt <= 2'd0;
          state      <= RD_STB;
        end
        RD_STB: begin
          if (strobe_cnt == 2'd0) begin
            strobe_cnt <= 2'd1;
          end else begin
            cmd     <= ft_bus;
            ft_rd_n <= 1'b1;
            ft_oe_n <= 1'b1;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Wait for RXF# to go high so a single low period yields one byte.
          if (rxf_sync[1]) state <= DECODE;
        end
        DECODE: begin
          if (cmd == CMD_GET_MCP) begin
            mcp_cs_n <= 1'b0;
            mcp_din  <= 1'b1;
            mcp_dclk <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= 6'd0;
            chan     <= 1'b0;
            state    <= MCP_CONV;
          end else if (cmd == CMD_SHUTTER_CLOSE) begin
            shutter_open <= 1'b0;
            rep_kind     <= REP_ACK;
            rep_idx      <= 9'd0;
            rep_last     <= 9'd0;
            state        <= TX_LOAD;
          end else if (cmd == CMD_READ_CCD) begin
            rep_kind <= REP_CCD;
            rep_idx  <= 9'd0;
            rep_last <= CCD_LAST;
            state    <= TX_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        MCP_CONV: begin
          div_cnt <= div_cnt + SPI_DIV_LOG2'(1);
          // Even half steps 0..32 are rising edges 1..17; odd 1..31 are falling edges.
          if (half_tick) begin
            half_cnt <= half_cnt + 6'd1;
            if (half_cnt <= 6'd32 && !half_cnt[0]) begin
              mcp_dclk <= 1'b1;
              if (half_cnt >= 6'd14) shift <= {shift[8:0], dout_sync[1]};
            end else if (half_cnt < 6'd33) begin
              mcp_dclk <= 1'b0;
              mcp_din  <= (half_cnt == 6'd1) || (half_cnt == 6'd7 && chan);
            end else if (half_cnt == 6'd33) begin
              mcp_dclk <= 1'b0;
              mcp_cs_n <= 1'b1;
              mcp_din  <= 1'b0;
              if (!chan) ch0 <= shift;
              else       ch1 <= shift;
            end else if (half_cnt == 6'd37) begin
              half_cnt <= 6'd0;
              if (!chan) begin
                chan     <= 1'b1;
                mcp_cs_n <= 1'b0;
                mcp_din  <= 1'b1;
              end else begin
                rep_kind <= REP_MCP;
                rep_idx  <= 9'd0;
                rep_last <= 9'd3;
                state    <= TX_LOAD;
              end
            end
          end
        end
        TX_LOAD: begin
          if (!txe_sync[1]) begin
            tx_data    <= rep_byte;
            tx_drive   <= 1'b1;
            strobe_cnt <= 2'd0;
            state      <= TX_STB;
          end
        end
        TX_STB: begin
          if (strobe_cnt == 2'd0) begin
            ft_wr_n    <= 1'b0;
            strobe_cnt <= 2'd1;
          end else if (strobe_cnt == 2'd1) begin
            strobe_cnt <= 2'd2;
          end else begin
            ft_wr_n <= 1'b1;
            state   <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          tx_drive <= 1'b0;
          if (rep_idx == rep_last) begin
`ifdef BB_SEND_IMMEDIATE_EN
            ft_siwu_n <= 1'b0;
            state     <= SIWU;
`else
            state <= IDLE;
`endif
          end else begin
            rep_idx <= rep_idx + 9'd1;
            state   <= TX_LOAD;
          end
        end
`ifdef BB_SEND_IMMEDIATE_EN
        SIWU: begin
          ft_siwu_n <= 1'b1;
          state     <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_breadboard_tests_core.sv
// Directed bench for breadboard_tests_core: FT232H host model, MCP3008 device model, reply-byte scoreboard.
module tb_breadboard_tests_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ft_rxf_n = 1'b1;
  logic       ft_txe_n = 1'b1;
  logic       ft_clkout = 1'b0;
  logic       mcp_dout = 1'b0;
  logic [7:0] host_data = 8'h00;
  wire  [7:0] ft_bus;
  logic       ft_rd_n, ft_wr_n, ft_siwu_n, ft_oe_n;
  logic       mcp_dclk, mcp_din, mcp_cs_n;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         rd_count = 0;
  int         wr_count = 0;
  int         cs_count = 0;
  int         edge_in_win = 0;
  logic [4:0] din_bits = 5'd0;
  int         win_edges[32];
  logic [4:0] win_din[32];
  int         win_len[32];
  int         win_start = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         adc_mode = 1'b0;
  logic [9:0] cur_word = 10'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // The host presents its byte whenever the DUT enables FT232H output.
  assign ft_bus = (ft_oe_n === 1'b0) ? host_data : 8'hzz;

  breadboard_tests_core dut (
    .clk_in   (clk),
    .rst_n    (rst_n),
    .ft_bus   (ft_bus),
    .ft_rxf_n (ft_rxf_n),
    .ft_txe_n (ft_txe_n),
    .ft_rd_n  (ft_rd_n),
    .ft_wr_n  (ft_wr_n),
    .ft_siwu_n(ft_siwu_n),
    .ft_clkout(ft_clkout),
    .ft_oe_n  (ft_oe_n),
    .mcp_dclk (mcp_dclk),
    .mcp_dout (mcp_dout),
    .mcp_din  (mcp_din),
    .mcp_cs_n (mcp_cs_n)
  );

  function automatic logic [9:0] adc_word(input int n);
    int v;
    v = (n * 147) ^ 32'h2A5;
    return v[9:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge ft_rd_n) if (mon_en) rd_count++;

  always @(negedge ft_wr_n) begin
    if (mon_en) begin
      logic       has_exp;
      logic [7:0] want;
      #1;
      wr_count++;
      has_exp = (exp_q.size() != 0);
      want = has_exp ? exp_q.pop_front() : 8'h00;
      checks++;
      assert (has_exp && ft_bus === want) else begin
        errors++;
        $error("FAIL reply_byte_%0d observed %h expected %h (queued=%0d)", wr_count, ft_bus, want, has_exp);
      end
      $display("byte %0d: %h", wr_count, ft_bus);
    end
  end

  always @(negedge mcp_cs_n) begin
    if (mon_en) begin
      cs_count++;
      edge_in_win = 0;
      din_bits = 5'd0;
      win_start = cyc;
      cur_word = adc_word(cs_count - 1);
    end
  end

  always @(posedge mcp_dclk) begin
    if (mon_en && mcp_cs_n === 1'b0) begin
      edge_in_win++;
      if (edge_in_win <= 5) din_bits = {din_bits[3:0], mcp_din};
    end
  end

  // MCP3008 model: null bit after edge 6, then B9..B0 on successive falling edges.
  always @(negedge mcp_dclk) begin
    if (mon_en && mcp_cs_n === 1'b0) begin
      if (!adc_mode) mcp_dout = 1'b1;
      else if (edge_in_win >= 7 && edge_in_win <= 16) mcp_dout = cur_word[16 - edge_in_win];
      else mcp_dout = 1'b0;
    end
  end

  always @(posedge mcp_cs_n) begin
    if (mon_en && cs_count > 0 && cs_count <= 32) begin
      win_edges[cs_count-1] = edge_in_win;
      win_din[cs_count-1]   = din_bits;
      win_len[cs_count-1]   = cyc - win_start;
      $display("conversion %0d: edges=%0d din=%b cycles=%0d", cs_count - 1, edge_in_win, din_bits, cyc - win_start);
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    int n;
    int start;
    n = 0;
    start = rd_count;
    @(negedge clk);
    host_data = b;
    ft_rxf_n = 1'b0;
    while (rd_count == start && n < 30000) begin
      @(negedge clk);
      n++;
    end
    ft_rxf_n = 1'b1;
    $display("command %h read after %0d cycles", b, n);
    check($sformatf("rd_strobe_cmd_%h", b), rd_count, start + 1);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic push_ccd(input logic [7:0] header);
    exp_q.push_back(header);
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
  endtask

  initial begin
    int base;
    int snap;
    int n;
    logic [9:0] w0;
    logic [9:0] w1;

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_rd_n", ft_rd_n, 1);
    check("rst_wr_n", ft_wr_n, 1);
    check("rst_oe_n", ft_oe_n, 1);
    check("rst_siwu_n", ft_siwu_n, 1);
    check("rst_cs_n", mcp_cs_n, 1);
    check("rst_dclk", mcp_dclk, 0);
    check("rst_din", mcp_din, 0);

    // Unknown opcodes are consumed one per RXF# low period and produce nothing.
    ft_txe_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_cmd(8'hF0 + 8'(i));
      repeat (20) @(negedge clk);
    end
    repeat (100) @(negedge clk);
    check("drop_rd_count", rd_count, 4);
    check("drop_wr_count", wr_count, 0);
    check("drop_cs_count", cs_count, 0);

    // GET_MCP with MCP dout held high.
    adc_mode = 1'b0;
    exp_q.push_back(8'h03); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h03); exp_q.push_back(8'hFF);
    send_cmd(8'h01);
    wait_drain("drain_mcp_single", 40000);
    check("mcp_cs_count", cs_count, 2);
    check("mcp_edges_ch0", win_edges[0], 17);
    check("mcp_edges_ch1", win_edges[1], 17);
    check("mcp_din_ch0", win_din[0], 5'b11000);
    check("mcp_din_ch1", win_din[1], 5'b11001);

    // Five GET_MCP back to back with distinct ADC codes per conversion.
    adc_mode = 1'b1;
    for (int j = 0; j < 5; j++) begin
      w0 = adc_word(2 + 2 * j);
      w1 = adc_word(3 + 2 * j);
      exp_q.push_back({6'b0, w0[9:8]}); exp_q.push_back(w0[7:0]);
      exp_q.push_back({6'b0, w1[9:8]}); exp_q.push_back(w1[7:0]);
    end
    for (int j = 0; j < 5; j++) send_cmd(8'h01);
    wait_drain("drain_mcp_x5", 60000);
    check("mcp_x5_cs_count", cs_count, 12);
    for (int k = 2; k < 12; k++) begin
      check($sformatf("mcp_x5_edges_%0d", k), win_edges[k], 17);
      check($sformatf("mcp_x5_window_lt_2ms_%0d", k), (win_len[k] < 200000) ? 1 : 0, 1);
    end

    // READ_CCD after reset, SHUTTER_CLOSE, then READ_CCD again.
    push_ccd(8'h01);
    send_cmd(8'h03);
    wait_drain("drain_ccd_open", 20000);
    exp_q.push_back(8'hA5);
    send_cmd(8'h02);
    wait_drain("drain_shutter_ack", 5000);
    push_ccd(8'h00);
    send_cmd(8'h03);
    wait_drain("drain_ccd_closed", 20000);

    // READ_CCD with TXE# high for ~1 us in the middle of the frame.
    base = wr_count;
    push_ccd(8'h00);
    send_cmd(8'h03);
    n = 0;
    while (wr_count < base + 20 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    ft_txe_n = 1'b1;
    repeat (10) @(negedge clk);
    snap = wr_count;
    repeat (100) @(negedge clk);
    check("stall_no_wr", wr_count, snap);
    ft_txe_n = 1'b0;
    wait_drain("drain_ccd_stall", 20000);
    check("stall_byte_total", wr_count, base + 65);

    repeat (50) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_cs_count", cs_count, 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
